// File: rtl/sysid_pkg.sv
// rtl/sysid_pkg.sv - shared states, read addresses and default expected words for sysid_checker
package sysid_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE       = 3'd0;
  localparam state_t RD_ID_REQ  = 3'd1;
  localparam state_t RD_ID_WAIT = 3'd2;
  localparam state_t RD_TS_REQ  = 3'd3;
  localparam state_t RD_TS_WAIT = 3'd4;
  localparam state_t DONE       = 3'd5;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEF_EXPECTED_ID        = 32'h0000_0000;
  localparam logic [31:0] DEF_EXPECTED_TIMESTAMP = 32'd1687264620;

  function automatic logic is_req(input state_t s);
    return (s == RD_ID_REQ) || (s == RD_TS_REQ);
  endfunction

  function automatic logic is_wait(input state_t s);
    return (s == RD_ID_WAIT) || (s == RD_TS_WAIT);
  endfunction

endpackage

// File: rtl/avm_read_timer.sv
// rtl/avm_read_timer.sv - per-transaction cycle counter with limit detect
module avm_read_timer #(
  parameter int LIMIT = 255,
  parameter int W     = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  // expired flags the cycle whose increment would reach LIMIT
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count >= LAST);

endmodule

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - Avalon-MM reader that checks system ID and build timestamp words
import sysid_pkg::*;

module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEF_EXPECTED_TIMESTAMP,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          TO_W               = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_t state, state_nxt;
  logic   expired;
  logic   timer_clr;
  logic   timeout_hit;

  avm_read_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TO_W)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (timer_clr),
    .inc     (is_req(state) || is_wait(state)),
    .expired (expired)
  );

  // Progress (accept or data) in the limit cycle beats the timeout.
  assign timeout_hit = expired &&
                       ((is_req(state) && avm_waitrequest) ||
                        (is_wait(state) && !avm_readdatavalid));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (start) state_nxt = RD_ID_REQ;
      RD_ID_REQ:  if (!avm_waitrequest) state_nxt = RD_ID_WAIT;
                  else if (expired)     state_nxt = DONE;
      RD_ID_WAIT: if (avm_readdatavalid) state_nxt = RD_TS_REQ;
                  else if (expired)      state_nxt = DONE;
      RD_TS_REQ:  if (!avm_waitrequest) state_nxt = RD_TS_WAIT;
                  else if (expired)     state_nxt = DONE;
      RD_TS_WAIT: if (avm_readdatavalid || expired) state_nxt = DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  assign timer_clr = is_req(state_nxt) && (state_nxt != state);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        id_ok    <= 1'b0;
        ts_ok    <= 1'b0;
        timeout  <= 1'b0;
        id_value <= '0;
        ts_value <= '0;
      end
      if (state == RD_ID_WAIT && avm_readdatavalid) begin
        id_value <= avm_readdata;
        id_ok    <= (avm_readdata == EXPECTED_ID);
      end
      if (state == RD_TS_WAIT && avm_readdatavalid) begin
        ts_value <= avm_readdata;
        ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
      end
      if (timeout_hit) timeout <= 1'b1;
    end
  end

  assign avm_read    = is_req(state);
  assign avm_address = (state == RD_TS_REQ) ? ADDR_TS : ADDR_ID;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign pass        = id_ok && ts_ok && !timeout;

endmodule

// File: tb/tb_sysid_checker.sv
// tb/tb_sysid_checker.sv - scoreboard bench for sysid_checker
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1687264620;
  localparam int          TO_CYC = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy, done, pass, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (TO_CYC),
    .TO_W               (16)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .id_ok             (id_ok),
    .ts_ok             (ts_ok),
    .timeout           (timeout),
    .id_value          (id_value),
    .ts_value          (ts_value)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int          at;
    logic        pass, id_ok, ts_ok, tmo;
    logic [31:0] idv, tsv;
  } exp_t;

  exp_t sb[$];

  // slave configuration
  logic [31:0] id_data, ts_data;
  int          stall_cfg = 0;
  bit          mute_id = 0;
  bit          late_req = 0;
  int          reads_run = 0;
  int          done_count = 0;

  initial begin : slave
    bit   pending = 0, pend_addr = 0, in_req = 0, stalled_prev = 0, addr_prev = 0;
    int   stall_left = 0;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clock);
      avm_readdatavalid = 1'b0;
      if (reset) begin
        pending = 0; in_req = 0; stalled_prev = 0;
        avm_waitrequest = 1'b0;
      end else begin
        if (stalled_prev) begin
          chk("read_held", avm_read, 1);
          chk("addr_held", avm_address, addr_prev);
        end
        if (late_req) begin
          late_req = 0;
          avm_readdatavalid = 1'b1;
          avm_readdata = EXP_ID;
        end else if (pending) begin
          pending = 0;
          if (!(mute_id && !pend_addr)) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = pend_addr ? ts_data : id_data;
          end
        end
        stalled_prev = 0;
        if (avm_read) begin
          if (!in_req) begin
            in_req = 1;
            stall_left = stall_cfg;
          end
          if (stall_left > 0) begin
            stall_left--;
            avm_waitrequest = 1'b1;
            stalled_prev = 1;
            addr_prev = avm_address;
          end else begin
            avm_waitrequest = 1'b0;
            chk("accept_addr", avm_address, reads_run);
            pending = 1;
            pend_addr = avm_address;
            in_req = 0;
            reads_run++;
          end
        end else begin
          avm_waitrequest = 1'b0;
          in_req = 0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (done) begin
        done_count++;
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.at);
          chk("pass", pass, e.pass);
          chk("id_ok", id_ok, e.id_ok);
          chk("ts_ok", ts_ok, e.ts_ok);
          chk("timeout", timeout, e.tmo);
          chk("id_value", id_value, e.idv);
          chk("ts_value", ts_value, e.tsv);
        end
      end
    end
  end

  task automatic run(input logic [31:0] idd, input logic [31:0] tsd, input int stall, input bit mute);
    exp_t e;
    id_data   = idd;
    ts_data   = tsd;
    stall_cfg = stall;
    mute_id   = mute;
    @(negedge clock);
    reads_run = 0;
    start = 1'b1;
    e.at    = mute ? cyc + 1 + TO_CYC : cyc + 5 + 2 * stall;
    e.idv   = mute ? 32'h0 : idd;
    e.tsv   = mute ? 32'h0 : tsd;
    e.id_ok = !mute && (idd == EXP_ID);
    e.ts_ok = !mute && (tsd == EXP_TS);
    e.tmo   = mute;
    e.pass  = e.id_ok && e.ts_ok && !e.tmo;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clock);
  endtask

  initial begin : main
    int dn;
    reset = 1'b1;
    start = 1'b0;
    id_data = EXP_ID;
    ts_data = EXP_TS;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_outputs", {avm_read, busy, done, pass, id_ok, ts_ok, timeout}, 0);
    chk("rst_id_value", id_value, 0);
    chk("rst_ts_value", ts_value, 0);

    run(EXP_ID, EXP_TS, 0, 0);
    drain();
    chk("nom_reads", reads_run, 2);
    chk("nom_pass_held", pass, 1);

    run(EXP_ID, EXP_TS + 1, 0, 0);
    drain();

    run(32'h1234_5678, EXP_TS, 0, 0);
    drain();

    run(EXP_ID, EXP_TS, 3, 0);
    drain();

    run(EXP_ID, EXP_TS, 0, 1);
    drain();
    chk("tmo_reads", reads_run, 1);
    late_req = 1;
    repeat (3) @(negedge clock);
    chk("late_id_ok", id_ok, 0);
    chk("late_busy", busy, 0);
    chk("late_tmo_held", timeout, 1);

    dn = done_count;
    run(EXP_ID, EXP_TS, 0, 0);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    drain();
    repeat (8) @(negedge clock);
    chk("busy_one_done", done_count - dn, 1);
    chk("busy_two_reads", reads_run, 2);

    run(EXP_ID, EXP_TS, 0, 0);
    repeat (3) @(negedge clock);
    chk("rst_mid_busy", busy, 1);
    reset = 1'b1;
    sb.delete();
    dn = done_count;
    @(negedge clock);
    reset = 1'b0;
    chk("rstmid_outputs", {avm_read, busy, done, pass, id_ok, ts_ok, timeout}, 0);
    chk("rstmid_values", id_value | ts_value, 0);
    repeat (8) @(negedge clock);
    chk("rstmid_no_done", done_count - dn, 0);

    run(EXP_ID, EXP_TS, 0, 0);
    drain();
    chk("post_rst_pass", pass, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Avalon-MM read master that sits directly downstream of the system-ID slave and consumes its two words.
- On a start pulse it reads address 0 (system ID) and then address 1 (build timestamp), and compares each word against its expected parameter value.
- It reports pass/fail, a timeout flag and both captured words.
- Software or a boot sequencer uses it to confirm that the loaded FPGA image matches the expected image before releasing the CPU.

Parameters:
- EXPECTED_ID, 32'h00000000, expected word at address 0.
- EXPECTED_TIMESTAMP, 32'd1687264620, expected word at address 1.
- TIMEOUT_CYCLES, 255, maximum cycles allowed per read transaction (1..65535).
- TO_W, 16, width of the timeout counter.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run a check; ignored while busy.
- avm_address  out  1  0 = system ID word, 1 = timestamp word.
- avm_read  out  1  Avalon read request.
- avm_waitrequest  in  1  slave/interconnect stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data qualifier.
- busy  out  1  check in progress.
- done  out  1  one-cycle pulse when a check completes (pass, fail or timeout).
- pass  out  1  id_ok & ts_ok & !timeout; held until the next start.
- id_ok  out  1  captured ID == EXPECTED_ID.
- ts_ok  out  1  captured timestamp == EXPECTED_TIMESTAMP.
- timeout  out  1  a transaction exceeded TIMEOUT_CYCLES.
- id_value  out  32  captured address-0 word.
- ts_value  out  32  captured address-1 word.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- State sequence: IDLE -> RD_ID_REQ -> RD_ID_WAIT -> RD_TS_REQ -> RD_TS_WAIT -> DONE -> IDLE.
- IDLE:
  - start=1 -> RD_ID_REQ.
  - Clear id_ok, ts_ok, pass, timeout, id_value and ts_value; set busy.
- *_REQ states:
  - avm_read=1; avm_address = 0 (ID) or 1 (TS).
  - Address and read stay stable while avm_waitrequest=1.
  - The request is accepted in the cycle where avm_read & !avm_waitrequest; the next state is the matching *_WAIT with avm_read=0.
- *_WAIT states:
  - On avm_readdatavalid=1, capture avm_readdata into id_value / ts_value.
  - Register the comparison result into id_ok / ts_ok in the same edge.
  - Advance to the next state.
  - avm_readdatavalid seen in any other state is ignored, including late data after a timeout.
- Timeout counter:
  - Cleared on entry to each *_REQ state.
  - Increments every cycle in *_REQ and *_WAIT.
  - When the count reaches TIMEOUT_CYCLES with no progress: set timeout=1, drop avm_read, go to DONE. Data from the aborted read is not captured.
  - If data arrives in the same cycle the count reaches the limit, data wins: capture it, no timeout.
- DONE: done=1 for exactly one cycle; pass computed from the registered flags; busy=0 on the next cycle; return to IDLE.
- Status outputs (pass, *_ok, timeout, *_value) hold until the next accepted start.
- Nominal latency, with zero wait states and readdatavalid one cycle after accept: start at cycle N -> done at N+5.
- start while busy (including in the DONE cycle) is dropped.
- Reset mid-transaction aborts immediately: avm_read=0 in the cycle after reset, all outputs cleared, no done pulse.
- No pipelining: at most one outstanding read.

Decomposition:
- Shared package sysid_pkg:
  - State enum (IDLE, RD_ID_REQ, RD_ID_WAIT, RD_TS_REQ, RD_TS_WAIT, DONE).
  - Address constants ADDR_ID=1'b0 and ADDR_TS=1'b1.
  - Default expected-value constants.
- Sub-module: avm_read_timer, holding the clear/increment/compare timeout counter. Everything else stays flat in sysid_checker.

Test Plan:
- Nominal: slave returns 0 at address 0 and 1687264620 at address 1, no waits; pulse start -> done at start+5, pass=1, id_ok=1, ts_ok=1, ts_value=1687264620.
- Timestamp mismatch: address 1 returns 1687264621 -> done, ts_ok=0, id_ok=1, pass=0, ts_value=1687264621.
- Back-pressure: waitrequest held 3 cycles on each read -> address and read stay stable throughout; done at start+11; pass=1.
- Timeout: TIMEOUT_CYCLES=8, readdatavalid never asserted for address 0 -> timeout=1, pass=0, done 8 cycles after RD_ID_REQ entry; no address-1 read issued; a late readdatavalid is ignored.
- Reset mid-operation: assert reset during RD_TS_WAIT -> next cycle all outputs 0, avm_read=0, no done pulse; a fresh start afterwards passes normally.
- Start while busy: a second start pulse in RD_ID_WAIT -> exactly one done pulse and exactly two reads observed.
